uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
// - Oversampling UART receiver; successor to the team's single-sample receiver.
// - Derives a baud tick internally, synchronises rx and samples each bit at mid-point by 3-sample majority.
// - Returns a registered word with a one-cycle valid strobe, framing-error flag and optional parity check.
// - Sits between the board rx pin and the host-side FIFO/command decoder.
// PARAMETERS
// - CLK_FREQ    50000000  system clock in Hz
// - BAUD_RATE   115200    line rate in baud
// - OVERSAMPLE  16        ticks per bit; even, >=4
// - DATA_BITS   8         data bits per frame, 5..9, LSB first
// - STOP_BITS   1         stop bits checked, 1 or 2
// - PARITY_ODD  0         0=even, 1=odd; used only with UART_RX_PARITY_EN
// PORTS
// - clk         in   1          system clock
// - reset       in   1          synchronous, active-high
// - rx          in   1          asynchronous serial line, idle high
// - data        out  DATA_BITS  last received word; updates only with data_valid
// - data_valid  out  1          one-cycle pulse: new word on data
// - frame_err   out  1          pulse with data_valid: a stop bit sampled 0
// - parity_err  out  1          pulse with data_valid: parity mismatch (0 without macro)
// - busy        out  1          high in any state other than IDLE
// BEHAVIOUR
// Clock and reset
// - clk is the single clock. reset is synchronous, active-high and overrides everything.
// - On reset: state=IDLE; data=0; data_valid, frame_err, parity_err and busy = 0.
// - Also on reset: the 2-flop synchroniser presets to 1; all counters go to 0.
// - Reset mid-frame abandons the frame silently; no strobe is generated.
// Tick generation
// - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer, must be >=1.
// - The divider emits a one-cycle tick every DIV clocks.
// - The divider and os_cnt are cleared on entry to START.
// - os_cnt counts 0..OVERSAMPLE-1 per bit and wraps.
// - Majority vote over ticks MID-1, MID, MID+1 (MID=OVERSAMPLE/2); the bit value is decided at MID+1.
// FSM
// - IDLE: synchronised rx==0 -> START.
// - START: at decision, bit=1 -> IDLE (glitch reject, no strobe); else -> DATA, bit_cnt=0.
// - DATA: each decision shifts the bit in LSB-first.
//   - At bit_cnt==DATA_BITS-1, go to PARITY (macro on) or STOP.
// - PARITY: compute parity_err from XOR of data bits, the parity bit and PARITY_ODD.
// - STOP: each of STOP_BITS decisions; any 0 sets frame_err.
//   - At the last stop decision: next cycle data<=shift reg, data_valid=1, flags valid.
//   - Then -> IDLE if the last stop bit was 1, else -> BREAK.
// - BREAK: wait for synchronised rx==1, then -> IDLE (out-of-sync recovery).
// - IDLE is re-entered mid-stop-bit, so back-to-back frames with no idle gap are received.
// Latency and flags
// - data_valid rises 1 clk after the last stop-bit decision; it never asserts for two consecutive cycles.
// - Flags are zero whenever data_valid is 0.
// Width rules
// - bit_cnt is $clog2(DATA_BITS+1) bits; os_cnt is $clog2(OVERSAMPLE) bits; the divider is $clog2(DIV+1) bits.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: a parity bit is expected after the data bits.
//   - parity_err is checked per PARITY_ODD.
// - UART_RX_PARITY_EN undefined: there is no PARITY state and the stop bit follows data directly.
//   - parity_err is tied 0 and PARITY_ODD is ignored.
// TESTING
// Bench configuration
// - CLK_FREQ=1843200, BAUD_RATE=115200, OVERSAMPLE=16 (DIV=1, 16 clk/bit), 8N1 unless stated.
// Directed scenarios
// 1. Frame 0xA5 -> data=0xA5, data_valid 1 clk, frame_err=0, busy low after the strobe.
// 2. rx low for 4 clks then high -> START rejects it; no data_valid; busy returns 0.
// 3. 0x3C with stop=0, rx held low 40 clks -> data=0x3C, frame_err=1.
//    - No new frame is accepted until rx goes high.
// 4. 0x00 then 0xFF back-to-back, zero idle -> two strobes 160 clks apart; data 0x00 then 0xFF.
// 5. reset at DATA bit 4 of 0x77, then frame 0x5A -> no strobe for 0x77; data=0x5A.
// 6. Macro on, PARITY_ODD=0, 0x81 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: internal baud tick, 2-flop rx synchroniser, 3-sample mid-bit majority vote.
// Define UART_RX_PARITY_EN to expect and check a parity bit after the data bits.
module uart_rx_os #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 data_valid_o,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 busy_o
);

   localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W = $clog2(DIV + 1);
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam int MID   = OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           sync_q;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [OS_W-1:0]      os_q, os_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_q, frame_d;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 par_q, par_d;
`endif

   logic rx_s;
   logic tick;
   logic decide;
   logic maj;

   assign rx_s   = sync_q[1];
   assign tick   = (state_q != S_IDLE) && (div_q == DIV_W'(DIV - 1));
   assign decide = tick && (os_q == OS_W'(MID + 1));
   // Samples from ticks MID-1 and MID are held; the MID+1 sample is the live synchronised line.
   assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
      state_d = state_q;
      div_d   = div_q;
      os_d    = os_q;
      bit_d   = bit_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      ferr_d  = ferr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      frame_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
      par_d   = 1'b0;
`endif

      if (state_q != S_IDLE) begin
         if (tick) begin
            div_d = '0;
            os_d  = (os_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;
            if (os_q == OS_W'(MID - 1)) samp_d[0] = rx_s;
            if (os_q == OS_W'(MID))     samp_d[1] = rx_s;
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               div_d   = '0;
               os_d    = '0;
               ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         S_START: begin
            if (decide) begin
               if (maj) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (decide) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (decide) begin
               perr_d  = (^shift_q) ^ maj ^ 1'(PARITY_ODD);
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (decide) begin
               if (!maj) ferr_d = 1'b1;
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  frame_d = ferr_q | ~maj;
`ifdef UART_RX_PARITY_EN
                  par_d   = perr_q;
`endif
                  // Leaving mid-stop-bit lets a following start edge be caught with no idle gap.
                  state_d = maj ? S_IDLE : S_BREAK;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         div_q   <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         samp_q  <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         par_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the previous cycle's values together.
         state_q <= state_d;
         sync_q  <= {sync_q[0], rx_i};
         div_q   <= div_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         samp_q  <= samp_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
         par_q   <= par_d;
`endif
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign frame_err_o  = frame_q;
   assign busy_o       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = par_q;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clocks per bit (DIV=1), 8N1; parity scenario when UART_RX_PARITY_EN is set.
module tb_uart_rx_os;

   localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_CLKS = BIT_CLKS * (10 + PAR_BITS);

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx_os #(
      .CLK_FREQ  (1843200),
      .BAUD_RATE (115200),
      .OVERSAMPLE(16),
      .DATA_BITS (8),
      .STOP_BITS (1),
      .PARITY_ODD(0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_i        (rx),
      .data_o      (data),
      .data_valid_o(data_valid),
      .frame_err_o (frame_err),
      .parity_err_o(parity_err),
      .busy_o      (busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
      end
   endtask

   // Strobe log, captured on the falling edge.
   logic [7:0] sd[$];
   logic       sf[$];
   logic       sp[$];
   int         sc[$];
   int         cyc        = 0;
   int         dbl_cnt    = 0;
   int         stray_cnt  = 0;
   int         perr_seen  = 0;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (data_valid) begin
            sd.push_back(data);
            sf.push_back(frame_err);
            sp.push_back(parity_err);
            sc.push_back(cyc);
            if (parity_err) perr_seen++;
            if (prev_valid) dbl_cnt++;
         end else if (frame_err || parity_err) begin
            stray_cnt++;
         end
      end
      prev_valid = data_valid;
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_body(input logic [7:0] d, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_BITS != 0) drive_bit((^d) ^ par_flip);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip);
      send_body(d, par_flip);
      drive_bit(1'b1);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_data", data, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_perr", parity_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;

      // Plain frame
      n = sd.size();
      send_frame(8'hA5, 1'b0);
      idle(32);
      check("s1_strobes", sd.size() - n, 1);
      check("s1_data", sd[sd.size()-1], 8'hA5);
      check("s1_ferr", sf[sf.size()-1], 1'b0);
      check("s1_data_port", data, 8'hA5);
      check("s1_busy", busy, 1'b0);

      // Short glitch rejected in START
      n = sd.size();
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("s2_busy_hi", busy, 1'b1);
      idle(30);
      check("s2_strobes", sd.size() - n, 0);
      check("s2_busy_lo", busy, 1'b0);

      // Stop bit low, line held low: framing error then BREAK
      n = sd.size();
      send_body(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("s3_strobes", sd.size() - n, 1);
      check("s3_data", sd[sd.size()-1], 8'h3C);
      check("s3_ferr", sf[sf.size()-1], 1'b1);
      check("s3_break_busy", busy, 1'b1);
      idle(20);
      check("s3_busy_lo", busy, 1'b0);
      check("s3_no_extra", sd.size() - n, 1);

      // Back-to-back frames, zero idle gap
      n = sd.size();
      send_frame(8'h00, 1'b0);
      send_frame(8'hFF, 1'b0);
      idle(32);
      check("s4_strobes", sd.size() - n, 2);
      if (sd.size() - n == 2) begin
         check("s4_data0", sd[n], 8'h00);
         check("s4_data1", sd[n+1], 8'hFF);
         check("s4_spacing", sc[n+1] - sc[n], FRAME_CLKS);
      end

      // Reset in DATA bit 4 of 0x77, then a clean frame
      n = sd.size();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(200);
      check("s5_no_strobe", sd.size() - n, 0);
      check("s5_busy", busy, 1'b0);
      check("s5_data_cleared", data, 8'h00);
      send_frame(8'h5A, 1'b0);
      idle(32);
      check("s5_strobes", sd.size() - n, 1);
      check("s5_data", data, 8'h5A);

`ifdef UART_RX_PARITY_EN
      // Even parity on 0x81: correct parity bit is 0
      n = sd.size();
      send_frame(8'h81, 1'b1);
      idle(32);
      send_frame(8'h81, 1'b0);
      idle(32);
      check("s6_strobes", sd.size() - n, 2);
      if (sd.size() - n == 2) begin
         check("s6_perr_bad", sp[n], 1'b1);
         check("s6_perr_good", sp[n+1], 1'b0);
         check("s6_data", sd[n+1], 8'h81);
      end
`else
      check("perr_tied_low", perr_seen, 0);
`endif

      check("valid_single_cycle", dbl_cnt, 0);
      check("flags_without_valid", stray_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
